// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and dispatch helper for the multicycle ALU.
package alu_pkg;

    // Opcode encoding carried on ctrl_i.
    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_MOD  = 3'b101;
    localparam logic [2:0] OP_AND  = 3'b110;
    localparam logic [2:0] OP_XOR  = 3'b111;

    // Control FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // True when the operation has to go through the iterative unit.
    // Division by zero is resolved immediately, so it never iterates.
    function automatic logic is_iterative(input logic [2:0] op, input logic b_zero);
        return (op == OP_MUL) || (((op == OP_DIV) || (op == OP_MOD)) && !b_zero);
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative shift-add multiplier / restoring divider, one step per strobe.
// hi/lo present the values the registers will hold after the current step,
// so the controller can capture the final result on the edge that runs it.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load,
    input  logic             step,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int CW = $clog2(WIDTH + 1);

    // acc: high partial product / partial remainder.
    // mq : multiplier shifting out, product low half shifting in;
    //      or dividend shifting out, quotient bits shifting in.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] operand_b;
    logic             mode_div;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // One-step datapath for both algorithms.
    always_comb begin
        sum     = {1'b0, acc} + (mq[0] ? {1'b0, operand_b} : '0);
        shifted = {acc, mq[WIDTH-1]};
        trial   = shifted - {1'b0, operand_b};
        if (mode_div) begin
            // Borrow out of the trial subtraction means shifted < divisor.
            if (!trial[WIDTH]) begin
                hi = trial[WIDTH-1:0];
                lo = {mq[WIDTH-2:0], 1'b1};
            end else begin
                hi = shifted[WIDTH-1:0];
                lo = {mq[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi = sum[WIDTH:1];
            lo = {sum[0], mq[WIDTH-1:1]};
        end
    end

    assign last = (count == CW'(1));

    // Iteration registers: loaded at request, advanced once per step strobe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc       <= '0;
            mq        <= '0;
            operand_b <= '0;
            mode_div  <= 1'b0;
            count     <= '0;
        end else if (load) begin
            acc       <= '0;
            mq        <= a;
            operand_b <= b;
            mode_div  <= div_mode;
            count     <= CW'(WIDTH);
        end else if (step) begin
            acc       <= hi;
            mq        <= lo;
            count     <= count - CW'(1);
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Clocked WIDTH-bit ALU with start/busy/done handshake. Single-cycle ops and
// divide-by-zero finish immediately; MUL/DIV/MOD run WIDTH iterations.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       ctrl_i,
    input  logic [WIDTH-1:0] data0_i,
    input  logic [WIDTH-1:0] data1_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic             zero_o,
    output logic             carry_o,
    output logic             err_o
);

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       op_q;

    logic             b_zero;
    logic             iter_load;
    logic             iter_step;
    logic             iter_last;
    logic [WIDTH-1:0] iter_lo;
    logic [WIDTH-1:0] iter_hi;

    logic             out_load;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] hi_nxt;
    logic             carry_nxt;
    logic             err_nxt;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    assign b_zero = (data1_i == '0);
    assign sum    = {1'b0, data0_i} + {1'b0, data1_i};
    assign diff   = {1'b0, data0_i} - {1'b0, data1_i};
    assign busy_o = (state != ST_IDLE);

    alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load     (iter_load),
        .step     (iter_step),
        .div_mode (ctrl_i != OP_MUL),
        .a        (data0_i),
        .b        (data1_i),
        .last     (iter_last),
        .lo       (iter_lo),
        .hi       (iter_hi)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and strobes: request dispatch, iteration, completion.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no latch is inferred.
        state_nxt = state;
        iter_load = 1'b0;
        iter_step = 1'b0;
        out_load  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    if (is_iterative(ctrl_i, b_zero)) begin
                        iter_load = 1'b1;
                        state_nxt = ST_CALC;
                    end else begin
                        out_load  = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_CALC: begin
                iter_step = 1'b1;
                if (iter_last) begin
                    out_load  = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Result/flag selection: iterative results in CALC, immediate ops otherwise.
    always_comb begin
        res_nxt   = '0;
        hi_nxt    = '0;
        carry_nxt = 1'b0;
        err_nxt   = 1'b0;
        if (state == ST_CALC) begin
            case (op_q)
                OP_MUL: begin
                    res_nxt   = iter_lo;
                    hi_nxt    = iter_hi;
                    carry_nxt = |iter_hi;
                end
                OP_DIV: begin
                    res_nxt = iter_lo;
                    hi_nxt  = iter_hi;
                end
                default: res_nxt = iter_hi;
            endcase
        end else begin
            case (ctrl_i)
                OP_PASS: res_nxt = data0_i;
                OP_ADD:  {carry_nxt, res_nxt} = sum;
                OP_SUB:  {carry_nxt, res_nxt} = diff;
                // Only reached with a zero divisor.
                OP_DIV: begin
                    res_nxt = '1;
                    hi_nxt  = data0_i;
                    err_nxt = 1'b1;
                end
                OP_MOD: begin
                    res_nxt = data0_i;
                    hi_nxt  = data0_i;
                    err_nxt = 1'b1;
                end
                OP_AND:  res_nxt = data0_i & data1_i;
                OP_XOR:  res_nxt = data0_i ^ data1_i;
                default: res_nxt = '0;
            endcase
        end
    end

    // Registered outputs: captured on the edge entering DONE, held until the next one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q        <= OP_PASS;
            done_o      <= 1'b0;
            result_o    <= '0;
            result_hi_o <= '0;
            zero_o      <= 1'b0;
            carry_o     <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            done_o <= (state == ST_DONE);
            if (iter_load) begin
                op_q <= ctrl_i;
            end
            if (out_load) begin
                result_o    <= res_nxt;
                result_hi_o <= hi_nxt;
                zero_o      <= (res_nxt == '0);
                carry_o     <= carry_nxt;
                err_o       <= err_nxt;
            end
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle at WIDTH 8 and WIDTH 16.
module tb_alu_multicycle;
    import alu_pkg::*;

    typedef struct {
        string       name;
        logic [15:0] res;
        logic [15:0] hi;
        logic        zero;
        logic        carry;
        logic        err;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    exp_t        q8[$];
    exp_t        q16[$];

    logic        start8 = 1'b0;
    logic [2:0]  ctrl8 = 3'd0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, zero8, carry8, err8;
    logic [7:0]  res8, hi8;

    logic        start16 = 1'b0;
    logic [2:0]  ctrl16 = 3'd0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, zero16, carry16, err16;
    logic [15:0] res16, hi16;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    alu_multicycle #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .ctrl_i(ctrl8),
        .data0_i(a8), .data1_i(b8), .busy_o(busy8), .done_o(done8),
        .result_o(res8), .result_hi_o(hi8), .zero_o(zero8),
        .carry_o(carry8), .err_o(err8)
    );

    alu_multicycle #(.WIDTH(16)) dut16 (
        .clk_i(clk), .rst_i(rst), .start_i(start16), .ctrl_i(ctrl16),
        .data0_i(a16), .data1_i(b16), .busy_o(busy16), .done_o(done16),
        .result_o(res16), .result_hi_o(hi16), .zero_o(zero16),
        .carry_o(carry16), .err_o(err16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic compare(input exp_t e, input logic [15:0] r, input logic [15:0] h,
                           input logic z, input logic c, input logic er);
        check({e.name, " result"}, 32'(r), 32'(e.res));
        check({e.name, " result_hi"}, 32'(h), 32'(e.hi));
        check({e.name, " zero"}, 32'(z), 32'(e.zero));
        check({e.name, " carry"}, 32'(c), 32'(e.carry));
        check({e.name, " err"}, 32'(er), 32'(e.err));
        check({e.name, " done cycle"}, 32'(cyc), 32'(e.due));
    endtask

    // Monitors: pop and compare whenever a DUT pulses done_o.
    always @(negedge clk) begin
        if (!rst && done8) begin
            if (q8.size() == 0) check("w8 spurious done", 32'(done8), 32'd0);
            else compare(q8.pop_front(), 16'(res8), 16'(hi8), zero8, carry8, err8);
        end
    end

    always @(negedge clk) begin
        if (!rst && done16) begin
            if (q16.size() == 0) check("w16 spurious done", 32'(done16), 32'd0);
            else compare(q16.pop_front(), res16, hi16, zero16, carry16, err16);
        end
    end

    // Issue one request once the target DUT is idle and queue its expectation.
    task automatic issue(input bit wide, input string name, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] er, input logic [15:0] eh,
                         input logic ez, input logic ec, input logic ee, input int lat);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while ((wide ? busy16 : busy8) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check({name, " idle timeout"}, 32'(n), 32'd0);
        if (wide) begin
            start16 = 1'b1; ctrl16 = op; a16 = a; b16 = b;
        end else begin
            start8 = 1'b1; ctrl8 = op; a8 = a[7:0]; b8 = b[7:0];
        end
        @(posedge clk);
        #1;
        start8  = 1'b0;
        start16 = 1'b0;
        e = '{name: name, res: er, hi: eh, zero: ez, carry: ec, err: ee, due: cyc + lat};
        if (wide) q16.push_back(e);
        else q8.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while ((q8.size() + q16.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain pending results", 32'(q8.size() + q16.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset outputs w8", {busy8, done8, res8, hi8, zero8, carry8, err8}, 32'd0);
        check("reset outputs w16", {busy16, done16, zero16, carry16, err16}, 32'd0);
        check("reset results w16", {res16, hi16}, 32'd0);
        rst = 1'b0;

        //    wide name        op       A      B      res    hi   z  c  e  lat
        issue(0, "add 200+100", OP_ADD,  200,   100,   44,    0,  0, 1, 0, 1);
        check("busy in done state", 32'(busy8), 32'd1);
        issue(0, "pass 10",     OP_PASS, 10,    77,    10,    0,  0, 0, 0, 1);
        issue(0, "sub 8-8",     OP_SUB,  8,     8,     0,     0,  1, 0, 0, 1);
        issue(0, "sub 3-7",     OP_SUB,  3,     7,     252,   0,  0, 1, 0, 1);
        issue(0, "and cc aa",   OP_AND,  8'hcc, 8'haa, 136,   0,  0, 0, 0, 1);
        issue(0, "xor cc aa",   OP_XOR,  8'hcc, 8'haa, 102,   0,  0, 0, 0, 1);
        issue(0, "mul 12*2",    OP_MUL,  12,    2,     24,    0,  0, 0, 0, 9);
        issue(0, "mul 255*255", OP_MUL,  255,   255,   1,     254, 0, 1, 0, 9);
        issue(0, "div 7/3",     OP_DIV,  7,     3,     2,     1,  0, 0, 0, 9);
        issue(0, "mod 7/3",     OP_MOD,  7,     3,     1,     0,  0, 0, 0, 9);
        issue(0, "mod 6/3",     OP_MOD,  6,     3,     0,     0,  1, 0, 0, 9);
        issue(0, "div 5/0",     OP_DIV,  5,     0,     255,   5,  0, 0, 1, 1);
        issue(0, "mod 9/0",     OP_MOD,  9,     0,     9,     9,  0, 0, 1, 1);

        // A request arriving mid-CALC must be dropped without disturbing the MUL.
        issue(0, "mul 15*17 with ignored add", OP_MUL, 15, 17, 255, 0, 0, 0, 0, 9);
        @(negedge clk);
        check("busy during calc", 32'(busy8), 32'd1);
        start8 = 1'b1; ctrl8 = OP_ADD; a8 = 8'd1; b8 = 8'd1;
        @(negedge clk);
        start8 = 1'b0;

        issue(1, "w16 mul 300*300",   OP_MUL, 300,   300, 24464, 1, 0, 1, 0, 17);
        issue(1, "w16 div 65535/255", OP_DIV, 65535, 255, 257,   0, 0, 0, 0, 17);
        drain();

        // Reset in the middle of an iteration discards it and clears all outputs.
        @(negedge clk);
        start8 = 1'b1; ctrl8 = OP_MUL; a8 = 8'd9; b8 = 8'd9;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("mid-calc reset outputs", {busy8, done8, res8, hi8, zero8, carry8, err8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(0, "add 1+2 after reset", OP_ADD, 1, 2, 3, 0, 0, 0, 0, 1);
        drain();
        repeat (12) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
